gecko_load_return: RTL and testbench



---
 rtl/gecko_load_return_if.sv | 45 ++++
 rtl/gecko_load_return.sv | 210 +++++++++++++++++++++
 tb/tb_gecko_load_return.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gecko_load_return_if.sv
// gecko_load_return_if: shared payload types for the load-return stage and a
// generic valid/ready stream interface carrying an opaque payload of WIDTH bits.
// The stage uses three instances: memory commands, memory read data and
// register writeback operations.

package gecko_load_return_pkg;

  // Load funct3 encodings understood by the load-return stage.
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // Load command issued by execute on its memory-command stream.
  typedef struct packed {
    logic [4:0] addr;          // destination register
    logic [2:0] op;            // load funct3
    logic [1:0] offset;        // byte offset within the memory word
    logic [3:0] reg_status;    // register scoreboard tag
    logic       jump_flag;
    logic       mispredicted;
  } gecko_mem_operation_t;

  // Register writeback operation handed to the writeback stage.
  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  addr;
    logic [3:0]  reg_status;
    logic        jump_flag;
    logic        mispredicted;
  } gecko_operation_t;

endpackage

interface gecko_load_return_if #(
  parameter int WIDTH = 32
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/gecko_load_return.sv
// gecko_load_return: load-return stage of the gecko core.
// Queues load commands from execute, pairs each non-mispredicted command with
// the next in-order memory read response, extracts and extends the loaded
// data and presents it as a registered writeback operation. Mispredicted
// commands retire without consuming a response.
// Optional feature: define GECKO_LOAD_RETURN_ALIGN_CHECK_EN to zero misaligned
// LH/LHU/LW results and pulse load_error when they retire.

module gecko_load_return
  import gecko_load_return_pkg::*;
#(
  parameter     CLOCK_INFO  = 'b0,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  gecko_load_return_if.slave  mem_command,
  gecko_load_return_if.slave  mem_result,
  gecko_load_return_if.master writeback_result,
  output logic                load_error
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  // The clock descriptor carries no information this stage acts on.
  logic unused_clock_info;
  assign unused_clock_info = |CLOCK_INFO;

  // ------------------------------------------------------------------
  // Data extraction: select byte/half by offset, then sign/zero extend.
  // ------------------------------------------------------------------
  function automatic logic [31:0] extract_load(input logic [2:0]  op,
                                               input logic [1:0]  offset,
                                               input logic [31:0] word);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] result;
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (op)
      FUNCT3_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_LBU: result = {24'b0, byte_sel};
      FUNCT3_LH:  result = {{16{half_sel[15]}}, half_sel};
      FUNCT3_LHU: result = {16'b0, half_sel};
      FUNCT3_LW:  result = word;
      default:    result = '0;
    endcase
    return result;
  endfunction

`ifdef GECKO_LOAD_RETURN_ALIGN_CHECK_EN
  // Halfwords must sit on an even offset, words on offset 0.
  function automatic logic is_misaligned(input logic [2:0] op,
                                         input logic [1:0] offset);
    logic bad;
    case (op)
      FUNCT3_LH, FUNCT3_LHU: bad = offset[0];
      FUNCT3_LW:             bad = (offset != 2'd0);
      default:               bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  gecko_mem_operation_t entries_q [QUEUE_DEPTH];
  gecko_mem_operation_t cmd_in;
  gecko_mem_operation_t head;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wb_valid_q, wb_valid_d;
  gecko_operation_t wb_data_q, wb_data_d;

  logic             queue_full;
  logic             queue_empty;
  logic             slot_can_load;
  logic             push;
  logic             pop;
  logic             rsp_ready;
  gecko_operation_t retire_op;
  logic             retire_err;

  assign cmd_in = mem_command.data;

  // Handshake decisions: queue flags, head selection, push/pop and response ready.
  always_comb begin
    queue_full    = (count_q == FULL_COUNT);
    queue_empty   = (count_q == '0);
    head          = entries_q[rd_ptr_q];
    // The output slot accepts a new operation when empty or being drained now.
    slot_can_load = !wb_valid_q || writeback_result.ready;
    // Full blocks a push even if the head retires in the same cycle.
    push          = mem_command.valid && !queue_full;
    rsp_ready     = !queue_empty && !head.mispredicted && slot_can_load;
    pop           = !queue_empty && slot_can_load &&
                    (head.mispredicted || mem_result.valid);
  end

  // Build the writeback operation for the current head entry.
  always_comb begin
    retire_op              = '0;
    retire_op.addr         = head.addr;
    retire_op.reg_status   = head.reg_status;
    retire_op.jump_flag    = head.jump_flag;
    retire_op.mispredicted = head.mispredicted;
    retire_err             = 1'b0;
    if (!head.mispredicted) begin
`ifdef GECKO_LOAD_RETURN_ALIGN_CHECK_EN
      retire_err = is_misaligned(head.op, head.offset);
`endif
      retire_op.value = retire_err ? 32'h0
                                   : extract_load(head.op, head.offset, mem_result.data);
    end
  end

  // Next-state: pointers, occupancy and output slot.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Slot holds its payload while valid && !ready; otherwise it reloads or empties.
    if (pop) begin
      wb_valid_d = 1'b1;
      wb_data_d  = retire_op;
    end else if (slot_can_load) begin
      wb_valid_d = 1'b0;
    end
  end

  // Command storage: written on push; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[wr_ptr_q] <= cmd_in;
    end
  end

  // Control and output-slot registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
    end
  end

`ifdef GECKO_LOAD_RETURN_ALIGN_CHECK_EN
  logic load_error_q, load_error_d;

  // Error flag rises with the offending writeback and lasts exactly one cycle.
  always_comb begin
    load_error_d = pop && retire_err;
  end

  // Error pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_error_q <= 1'b0;
    end else begin
      load_error_q <= load_error_d;
    end
  end

  assign load_error = load_error_q;
`else
  assign load_error = 1'b0;
`endif

  assign mem_command.ready      = !queue_full;
  assign mem_result.ready       = rsp_ready;
  assign writeback_result.valid = wb_valid_q;
  assign writeback_result.data  = wb_data_q;

endmodule

// File: tb/tb_gecko_load_return.sv
// Testbench for gecko_load_return: directed scenarios plus randomized traffic
// checked against an in-order behavioural model of load retirement.

module tb_gecko_load_return;
  import gecko_load_return_pkg::*;

  localparam int DEPTH = 4;

`ifdef GECKO_LOAD_RETURN_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_error;

  always #5 clk = ~clk;

  gecko_load_return_if #(.WIDTH($bits(gecko_mem_operation_t))) cmd_if ();
  gecko_load_return_if #(.WIDTH(32))                            rsp_if ();
  gecko_load_return_if #(.WIDTH($bits(gecko_operation_t)))     wb_if  ();

  gecko_load_return #(
    .CLOCK_INFO  ('b0),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_command      (cmd_if),
    .mem_result       (rsp_if),
    .writeback_result (wb_if),
    .load_error       (load_error)
  );

  int checks   = 0;
  int failures = 0;

  gecko_mem_operation_t cmd_q[$];
  logic [31:0]          rsp_q[$];
  gecko_operation_t     exp_q[$];
  bit                   exp_err_q[$];

  // Random command with the given op/offset/mispredict flag.
  function automatic gecko_mem_operation_t mk(input logic [2:0] op, input logic [1:0] off,
                                              input bit misp);
    gecko_mem_operation_t r;
    r.addr         = 5'($urandom_range(31));
    r.op           = op;
    r.offset       = off;
    r.reg_status   = 4'($urandom_range(15));
    r.jump_flag    = 1'($urandom_range(1));
    r.mispredicted = misp;
    return r;
  endfunction

  // Reference: what the writeback stage should receive for command c and word d.
  function automatic void model(input gecko_mem_operation_t c, input logic [31:0] d,
                                output gecko_operation_t e, output bit err);
    int unsigned b;
    int unsigned h;
    bit bad;
    e.addr         = c.addr;
    e.reg_status   = c.reg_status;
    e.jump_flag    = c.jump_flag;
    e.mispredicted = c.mispredicted;
    e.value        = 32'h0;
    err            = 1'b0;
    if (!c.mispredicted) begin
      b   = (d >> (8 * c.offset)) & 32'hFF;
      h   = (d >> (16 * c.offset[1])) & 32'hFFFF;
      bad = ALIGN_EN && ((((c.op == 3'd1) || (c.op == 3'd5)) && c.offset[0]) ||
                         ((c.op == 3'd2) && (c.offset != 2'd0)));
      if (bad) begin
        err = 1'b1;
      end else begin
        case (c.op)
          3'd0:    e.value = (b >= 128) ? b + 32'hFFFF_FF00 : b;
          3'd4:    e.value = b;
          3'd1:    e.value = (h >= 32768) ? h + 32'hFFFF_0000 : h;
          3'd5:    e.value = h;
          3'd2:    e.value = d;
          default: e.value = 32'h0;
        endcase
      end
    end
  endfunction

  task automatic clear_model();
    cmd_q.delete();
    rsp_q.delete();
    exp_q.delete();
    exp_err_q.delete();
  endtask

  task automatic enqueue(input gecko_mem_operation_t c, input logic [31:0] d);
    gecko_operation_t e;
    bit err;
    model(c, d, e, err);
    cmd_q.push_back(c);
    if (!c.mispredicted) rsp_q.push_back(d);
    exp_q.push_back(e);
    exp_err_q.push_back(err);
  endtask

  // Drive queued commands/responses with random valid/ready and check every writeback.
  task automatic run_traffic(input int cmd_pct, input int rsp_pct, input int rdy_pct,
                             input int hold, input int budget, input string tag);
    int cyc;
    bit stalled;
    bit exp_le;
    gecko_operation_t held;
    gecko_operation_t got;
    gecko_operation_t want;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(posedge clk); #1;
      cmd_if.valid = (cmd_q.size() > 0) && ($urandom_range(99) < cmd_pct);
      if (cmd_q.size() > 0) cmd_if.data = cmd_q[0];
      rsp_if.valid = (rsp_q.size() > 0) && ($urandom_range(99) < rsp_pct);
      if (rsp_q.size() > 0) rsp_if.data = rsp_q[0];
      wb_if.ready = (cyc >= hold) && ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      got = wb_if.data;
      if (stalled) begin
        checks++;
        if (wb_if.valid !== 1'b1 || got !== held) begin
          failures++;
          $display("FAIL %s_hold_stable: got valid=%0b data=%h, required valid=1 data=%h",
                   tag, wb_if.valid, got, held);
        end
      end
      exp_le = (wb_if.valid && !stalled && exp_err_q.size() > 0) ? exp_err_q[0] : 1'b0;
      checks++;
      if (load_error !== exp_le) begin
        failures++;
        $display("FAIL %s_load_error: got=%0b required=%0b", tag, load_error, exp_le);
      end
      if (wb_if.valid && !wb_if.ready) begin
        checks++;
        if (rsp_if.ready !== 1'b0) begin
          failures++;
          $display("FAIL %s_rsp_ready_stall: got=%0b required=0", tag, rsp_if.ready);
        end
        stalled = 1'b1;
        held = got;
      end else begin
        stalled = 1'b0;
      end
      if (wb_if.valid && wb_if.ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s_extra_writeback: got=%h required=none", tag, got);
        end else begin
          want = exp_q.pop_front();
          void'(exp_err_q.pop_front());
          if (got !== want) begin
            failures++;
            $display("FAIL %s_writeback: got=%h required=%h", tag, got, want);
          end
        end
      end
      if (cmd_if.valid && cmd_if.ready) void'(cmd_q.pop_front());
      if (rsp_if.valid && rsp_if.ready) void'(rsp_q.pop_front());
      cyc++;
    end
    @(posedge clk); #1;
    cmd_if.valid = 1'b0;
    rsp_if.valid = 1'b0;
    wb_if.ready  = 1'b1;
    checks++;
    if (exp_q.size() != 0 || rsp_q.size() != 0 || cmd_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: pending wb=%0d rsp=%0d cmd=%0d required 0/0/0",
               tag, exp_q.size(), rsp_q.size(), cmd_q.size());
    end else begin
      @(negedge clk);
      checks++;
      if (wb_if.valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_idle_after_drain: got valid=%0b required=0", tag, wb_if.valid);
      end
    end
    $display("[%0t] %s: traffic finished after %0d cycles", $time, tag, cyc);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_if.valid = 1'b0; cmd_if.data = '0;
    rsp_if.valid = 1'b0; rsp_if.data = '0;
    wb_if.ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wb_if.valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid: got=%0b required=0", wb_if.valid); end
    checks++;
    if (rsp_if.ready !== 1'b0) begin failures++; $display("FAIL reset_rsp_ready: got=%0b required=0", rsp_if.ready); end
    checks++;
    if (load_error !== 1'b0) begin failures++; $display("FAIL reset_load_error: got=%0b required=0", load_error); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_if.ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got=%0b required=1", cmd_if.ready); end
    checks++;
    if (rsp_if.ready !== 1'b0) begin failures++; $display("FAIL reset_rsp_ready_after: got=%0b required=0", rsp_if.ready); end
    $display("[%0t] reset: released", $time);
  endtask

  task automatic test_load_byte();
    gecko_mem_operation_t c;
    gecko_operation_t e;
    bit err;
    logic [31:0] d;
    c = mk(FUNCT3_LB, 2'd3, 1'b0);
    d = 32'h80FF_FF12;
    model(c, d, e, err);
    @(posedge clk); #1;
    cmd_if.valid = 1'b1; cmd_if.data = c; wb_if.ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_if.ready !== 1'b1) begin failures++; $display("FAIL lb_cmd_ready: got=%0b required=1", cmd_if.ready); end
    @(posedge clk); #1;
    cmd_if.valid = 1'b0; rsp_if.valid = 1'b1; rsp_if.data = d;
    @(negedge clk);
    checks++;
    if (rsp_if.ready !== 1'b1) begin failures++; $display("FAIL lb_rsp_ready: got=%0b required=1", rsp_if.ready); end
    checks++;
    if (wb_if.valid !== 1'b0) begin failures++; $display("FAIL lb_early_valid: got=%0b required=0", wb_if.valid); end
    @(posedge clk); #1;
    rsp_if.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_if.valid !== 1'b1 || wb_if.data !== e) begin
      failures++; $display("FAIL lb_writeback: got valid=%0b data=%h required valid=1 data=%h", wb_if.valid, wb_if.data, e);
    end
    checks++;
    if (wb_if.data[42:11] !== 32'hFFFF_FF80) begin
      failures++; $display("FAIL lb_value: got=%h required=ffffff80", wb_if.data[42:11]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (wb_if.valid !== 1'b0) begin failures++; $display("FAIL lb_single_wb: got=%0b required=0", wb_if.valid); end
    $display("[%0t] load_byte: LB o=3 of %h -> %h", $time, d, e.value);
  endtask

  task automatic test_back_to_back();
    gecko_mem_operation_t c [3];
    logic [31:0] d [3];
    logic [31:0] want_val [3];
    gecko_operation_t e [3];
    bit err;
    c[0] = mk(FUNCT3_LHU, 2'd2, 1'b0); d[0] = 32'hBEEF_0000; want_val[0] = 32'h0000_BEEF;
    c[1] = mk(FUNCT3_LH,  2'd0, 1'b0); d[1] = 32'h0000_8001; want_val[1] = 32'hFFFF_8001;
    c[2] = mk(FUNCT3_LW,  2'd0, 1'b0); d[2] = 32'h1234_5678; want_val[2] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) model(c[i], d[i], e[i], err);
    wb_if.ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      cmd_if.valid = (k < 3);
      if (k < 3) cmd_if.data = c[k];
      rsp_if.valid = (k >= 1) && (k <= 3);
      if (k >= 1 && k <= 3) rsp_if.data = d[k-1];
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (wb_if.valid !== 1'b1 || wb_if.data !== e[k-2] || wb_if.data[42:11] !== want_val[k-2]) begin
          failures++;
          $display("FAIL b2b_wb%0d: got valid=%0b data=%h required valid=1 data=%h", k-2, wb_if.valid, wb_if.data, e[k-2]);
        end
      end
    end
    @(posedge clk); #1;
    rsp_if.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_if.valid !== 1'b0) begin failures++; $display("FAIL b2b_idle: got=%0b required=0", wb_if.valid); end
    $display("[%0t] back_to_back: three loads retired on consecutive cycles", $time);
  endtask

  task automatic test_queue_full();
    gecko_mem_operation_t c [5];
    logic [31:0] d [5];
    gecko_operation_t e;
    bit err;
    clear_model();
    for (int i = 0; i < 5; i++) begin
      c[i] = mk(FUNCT3_LBU, 2'($urandom_range(3)), 1'b0);
      d[i] = $urandom;
      model(c[i], d[i], e, err);
      exp_q.push_back(e);
      exp_err_q.push_back(err);
      if (i > 0) rsp_q.push_back(d[i]);
    end
    wb_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cmd_if.valid = 1'b1; cmd_if.data = c[i];
      @(negedge clk);
      checks++;
      if (cmd_if.ready !== 1'b1) begin failures++; $display("FAIL full_accept%0d: got=%0b required=1", i, cmd_if.ready); end
    end
    @(posedge clk); #1;
    cmd_if.data = c[4];
    @(negedge clk);
    checks++;
    if (cmd_if.ready !== 1'b0) begin failures++; $display("FAIL full_ready_low: got=%0b required=0", cmd_if.ready); end
    @(posedge clk); #1;
    rsp_if.valid = 1'b1; rsp_if.data = d[0];
    @(negedge clk);
    checks++;
    if (cmd_if.ready !== 1'b0) begin failures++; $display("FAIL full_no_push_on_pop: got=%0b required=0", cmd_if.ready); end
    checks++;
    if (rsp_if.ready !== 1'b1) begin failures++; $display("FAIL full_rsp_ready: got=%0b required=1", rsp_if.ready); end
    @(posedge clk); #1;
    rsp_if.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_if.ready !== 1'b1) begin failures++; $display("FAIL full_ready_reopen: got=%0b required=1", cmd_if.ready); end
    @(posedge clk); #1;
    cmd_if.valid = 1'b0;
    $display("[%0t] queue_full: 5th command accepted after one retire", $time);
    run_traffic(100, 100, 100, 0, 100, "full_drain");
  endtask

  task automatic test_mispredict();
    gecko_mem_operation_t c0, c1;
    gecko_operation_t e0, e1;
    bit err;
    logic [31:0] d;
    c0 = mk(FUNCT3_LW, 2'd0, 1'b1);
    c1 = mk(FUNCT3_LBU, 2'd1, 1'b0);
    d  = 32'h0000_AB00;
    model(c0, 32'h0, e0, err);
    model(c1, d, e1, err);
    wb_if.ready = 1'b1;
    @(posedge clk); #1;
    cmd_if.valid = 1'b1; cmd_if.data = c0;
    @(posedge clk); #1;
    cmd_if.data = c1; rsp_if.valid = 1'b1; rsp_if.data = d;
    @(negedge clk);
    checks++;
    if (rsp_if.ready !== 1'b0) begin failures++; $display("FAIL misp_rsp_not_taken: got=%0b required=0", rsp_if.ready); end
    @(posedge clk); #1;
    cmd_if.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_if.valid !== 1'b1 || wb_if.data !== e0 || wb_if.data[42:11] !== 32'h0 || wb_if.data[0] !== 1'b1) begin
      failures++; $display("FAIL misp_wb: got valid=%0b data=%h required valid=1 data=%h", wb_if.valid, wb_if.data, e0);
    end
    checks++;
    if (rsp_if.ready !== 1'b1) begin failures++; $display("FAIL misp_next_rsp_ready: got=%0b required=1", rsp_if.ready); end
    @(posedge clk); #1;
    rsp_if.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_if.valid !== 1'b1 || wb_if.data !== e1 || wb_if.data[42:11] !== 32'h0000_00AB) begin
      failures++; $display("FAIL misp_second_wb: got valid=%0b data=%h required valid=1 data=%h", wb_if.valid, wb_if.data, e1);
    end
    $display("[%0t] mispredict: retired without response, then LBU -> %h", $time, e1.value);
  endtask

  task automatic test_backpressure();
    clear_model();
    enqueue(mk(FUNCT3_LB, 2'($urandom_range(3)), 1'b0), $urandom);
    enqueue(mk(FUNCT3_LW, 2'd0, 1'b1), 32'h0);
    enqueue(mk(FUNCT3_LBU, 2'($urandom_range(3)), 1'b0), $urandom);
    enqueue(mk(FUNCT3_LW, 2'd0, 1'b0), $urandom);
    run_traffic(100, 100, 100, 8, 100, "backpressure");
  endtask

  task automatic test_align();
    clear_model();
    enqueue(mk(FUNCT3_LW, 2'd2, 1'b0), 32'hCAFE_F00D);
    enqueue(mk(FUNCT3_LH, 2'd1, 1'b0), 32'h8765_4321);
    enqueue(mk(FUNCT3_LW, 2'd0, 1'b0), 32'h0BAD_BEEF);
    enqueue(mk(FUNCT3_LHU, 2'd3, 1'b0), 32'hF00D_9999);
    enqueue(mk(FUNCT3_LW, 2'd1, 1'b1), 32'h0);
    run_traffic(100, 100, 100, 0, 100, "align");
  endtask

  task automatic test_random();
    logic [2:0] op;
    clear_model();
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(7));
      enqueue(mk(op, 2'($urandom_range(3)), $urandom_range(99) < 20), $urandom);
    end
    run_traffic(70, 60, 70, 0, 3000, "random");
  endtask

  task automatic test_reset_midstream();
    gecko_mem_operation_t c [4];
    clear_model();
    for (int i = 0; i < 4; i++) c[i] = mk(FUNCT3_LW, 2'd0, 1'b0);
    wb_if.ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      cmd_if.valid = 1'b1; cmd_if.data = c[k];
      rsp_if.valid = (k == 1); rsp_if.data = 32'h1111_2222;
    end
    @(posedge clk); #1;
    cmd_if.valid = 1'b0; rsp_if.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_if.valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid: got=%0b required=1", wb_if.valid); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (wb_if.valid !== 1'b0) begin failures++; $display("FAIL midrst_wb_valid: got=%0b required=0", wb_if.valid); end
    checks++;
    if (rsp_if.ready !== 1'b0) begin failures++; $display("FAIL midrst_rsp_ready: got=%0b required=0", rsp_if.ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rsp_if.valid = 1'b1; rsp_if.data = 32'h5555_AAAA;
    wb_if.ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_if.ready !== 1'b1) begin failures++; $display("FAIL midrst_cmd_ready: got=%0b required=1", cmd_if.ready); end
    checks++;
    if (rsp_if.ready !== 1'b0) begin failures++; $display("FAIL midrst_queue_empty: got rsp_ready=%0b required=0", rsp_if.ready); end
    @(posedge clk); #1;
    rsp_if.valid = 1'b0;
    $display("[%0t] reset_midstream: queue flushed", $time);
    enqueue(mk(FUNCT3_LW, 2'd0, 1'b0), 32'h600D_CAFE);
    run_traffic(100, 100, 100, 0, 50, "post_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_byte();
    test_back_to_back();
    test_queue_full();
    test_mispredict();
    test_backpressure();
    test_align();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
